// File: rtl/atm_pin_entry.sv
// ATM keypad PIN entry: collects BCD digits while a card is present, checks them
// against the card's stored PIN, and enforces the attempt limit and a timed lockout.
module atm_pin_entry #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCK_CYCLES    = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        card_inserted,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] stored_pin,
  output logic        pin_entered,
  output logic        pin_ok,
  output logic        locked,
  output logic        entry_timeout,
  output logic [2:0]  digit_count,
  output logic [1:0]  attempts
);

  localparam int BUF_W   = 4 * PIN_DIGITS;
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_DONE,
    S_LOCKED
  } state_t;

  state_t               state_reg, state_next;
  logic [BUF_W-1:0]     buffer_reg, buffer_next;
  logic [2:0]           count_reg, count_next;
  logic [1:0]           attempts_reg, attempts_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [LOCK_W-1:0]    lock_cnt_reg, lock_cnt_next;
  logic                 pin_entered_reg, pin_entered_next;
  logic                 pin_ok_reg, pin_ok_next;
  logic                 locked_reg, locked_next;
  logic                 timeout_reg, timeout_next;

  logic [PIN_DIGITS-1:0] digit_match;
  logic                  pin_match;
  logic                  is_digit;
  logic                  buffer_full;
  logic [1:0]            attempts_inc;

  // Per-digit comparison; the buffer itself never leaves this module.
  genvar gi;
  generate
    for (gi = 0; gi < PIN_DIGITS; gi++) begin : g_digit
      assign digit_match[gi] = (buffer_reg[4*gi +: 4] == stored_pin[4*gi +: 4]);
    end
  endgenerate

  assign pin_match    = &digit_match;
  assign is_digit     = (key_code <= 4'd9);
  assign buffer_full  = (count_reg == 3'(PIN_DIGITS));
  assign attempts_inc = attempts_reg + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      buffer_reg      <= '0;
      count_reg       <= '0;
      attempts_reg    <= '0;
      timer_reg       <= '0;
      lock_cnt_reg    <= '0;
      pin_entered_reg <= 1'b0;
      pin_ok_reg      <= 1'b0;
      locked_reg      <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      buffer_reg      <= buffer_next;
      count_reg       <= count_next;
      attempts_reg    <= attempts_next;
      timer_reg       <= timer_next;
      lock_cnt_reg    <= lock_cnt_next;
      pin_entered_reg <= pin_entered_next;
      pin_ok_reg      <= pin_ok_next;
      locked_reg      <= locked_next;
      timeout_reg     <= timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    buffer_next      = buffer_reg;
    count_next       = count_reg;
    attempts_next    = attempts_reg;
    timer_next       = timer_reg;
    lock_cnt_next    = lock_cnt_reg;
    pin_entered_next = 1'b0;
    pin_ok_next      = 1'b0;
    timeout_next     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        buffer_next   = '0;
        count_next    = '0;
        attempts_next = '0;
        timer_next    = '0;
        lock_cnt_next = '0;
        if (card_inserted) state_next = S_COLLECT;
      end

      S_COLLECT: begin
        if (!card_inserted) begin
          state_next    = S_IDLE;
          buffer_next   = '0;
          count_next    = '0;
          attempts_next = '0;
          timer_next    = '0;
        end else if (key_valid) begin
          // Any key, even an unused code, counts as activity.
          timer_next = '0;
          if (is_digit) begin
            if (!buffer_full) begin
              buffer_next = {buffer_reg[BUF_W-5:0], key_code};
              count_next  = count_reg + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            buffer_next = '0;
            count_next  = '0;
          end else if (key_code == KEY_ENTER && buffer_full) begin
            state_next = S_CHECK;
          end
        end else if (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          buffer_next  = '0;
          count_next   = '0;
          timer_next   = '0;
          timeout_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      S_CHECK: begin
        buffer_next = '0;
        count_next  = '0;
        timer_next  = '0;
        if (!card_inserted) begin
          state_next    = S_IDLE;
          attempts_next = '0;
        end else begin
          pin_entered_next = 1'b1;
          pin_ok_next      = pin_match;
          if (pin_match) begin
            state_next = S_DONE;
          end else begin
            attempts_next = attempts_inc;
            if (attempts_inc == 2'(MAX_ATTEMPTS)) begin
              state_next    = S_LOCKED;
              lock_cnt_next = '0;
            end else begin
              state_next = S_COLLECT;
            end
          end
        end
      end

      S_DONE: begin
        if (!card_inserted) state_next = S_IDLE;
      end

      S_LOCKED: begin
        // Lockout runs to completion regardless of the card.
        if (lock_cnt_reg == LOCK_W'(LOCK_CYCLES - 1)) begin
          state_next    = S_IDLE;
          attempts_next = '0;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next    = S_IDLE;
        buffer_next   = '0;
        count_next    = '0;
        attempts_next = '0;
        timer_next    = '0;
        lock_cnt_next = '0;
      end
    endcase

    locked_next = (state_next == S_LOCKED);
  end

  assign pin_entered   = pin_entered_reg;
  assign pin_ok        = pin_ok_reg;
  assign locked        = locked_reg;
  assign entry_timeout = timeout_reg;
  assign digit_count   = count_reg;
  assign attempts      = attempts_reg;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Self-checking bench for atm_pin_entry: expected entry results are queued when
// Enter is driven and matched against each pin_entered pulse by a monitor.
module tb_atm_pin_entry;

  logic        clk;
  logic        reset;
  logic        card_inserted;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] stored_pin;
  logic        pin_entered;
  logic        pin_ok;
  logic        locked;
  logic        entry_timeout;
  logic [2:0]  digit_count;
  logic [1:0]  attempts;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit ok;
    int due;
  } exp_t;

  exp_t sb[$];

  atm_pin_entry #(
    .PIN_DIGITS(4),
    .MAX_ATTEMPTS(3),
    .TIMEOUT_CYCLES(1000),
    .LOCK_CYCLES(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .card_inserted(card_inserted),
    .key_valid(key_valid),
    .key_code(key_code),
    .stored_pin(stored_pin),
    .pin_entered(pin_entered),
    .pin_ok(pin_ok),
    .locked(locked),
    .entry_timeout(entry_timeout),
    .digit_count(digit_count),
    .attempts(attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pin_entered pulse must match the oldest queued expectation, on its due cycle.
  always @(negedge clk) begin
    if (pin_entered === 1'b1) begin
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pin_entered: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        if (pin_ok !== e.ok || cyc != e.due) begin
          fails++;
          $display("FAIL entry_result: got pin_ok=%0b at cycle %0d, required pin_ok=%0b at cycle %0d",
                   pin_ok, cyc, e.ok, e.due);
        end else begin
          $display("[TB] entry pin_ok=%0b at cycle %0d", pin_ok, cyc);
        end
      end
    end
  end

  task automatic press(input logic [3:0] code, input bit push = 0, input bit ok = 0);
    exp_t e;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    if (push) begin
      e.ok  = ok;
      e.due = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic submit(input logic [15:0] pin, input bit ok);
    for (int d = 3; d >= 0; d--) press(pin[4*d +: 4]);
    press(4'hB, 1'b1, ok);
  endtask

  task automatic card_on();
    @(negedge clk);
    card_inserted = 1'b1;
  endtask

  task automatic card_off();
    @(negedge clk);
    card_inserted = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({pin_entered, pin_ok, locked, entry_timeout, digit_count, attempts} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 0",
               {pin_entered, pin_ok, locked, entry_timeout, digit_count, attempts});
    end else $display("[TB] reset outputs zero");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_correct_pin();
    stored_pin = 16'h1234;
    card_on();
    submit(16'h1234, 1'b1);
    repeat (3) @(negedge clk);
    tests++;
    if (attempts !== 2'd0 || digit_count !== 3'd0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL correct_state: got attempts=%0d count=%0d locked=%0b, required 0 0 0",
               attempts, digit_count, locked);
    end else $display("[TB] correct pin accepted");
    press(4'h7);  // DONE ignores keys
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL done_ignores_keys: got count=%0d, required 0", digit_count);
    end else $display("[TB] DONE ignores keys");
    card_off();
  endtask

  task automatic test_edit_overflow();
    card_on();
    press(4'h9);
    tests++;
    if (digit_count !== 3'd1) begin
      fails++;
      $display("FAIL edit_first_digit: got count=%0d, required 1", digit_count);
    end else $display("[TB] digit buffered");
    press(4'hA);
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL edit_clear: got count=%0d, required 0", digit_count);
    end else $display("[TB] clear empties buffer");
    for (int d = 1; d <= 5; d++) press(4'(d));
    tests++;
    if (digit_count !== 3'd4) begin
      fails++;
      $display("FAIL overflow_count: got count=%0d, required 4", digit_count);
    end else $display("[TB] fifth digit ignored");
    press(4'hB, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    card_off();
  endtask

  task automatic test_lockout();
    int cnt;
    card_on();
    for (int i = 0; i < 2; i++) begin
      submit(16'h0000, 1'b0);
      @(negedge clk);
      tests++;
      if (attempts !== 2'(i + 1) || locked !== 1'b0) begin
        fails++;
        $display("FAIL lock_attempts_%0d: got attempts=%0d locked=%0b, required %0d 0",
                 i, attempts, locked, i + 1);
      end else $display("[TB] wrong entry %0d counted", i + 1);
    end
    submit(16'h0000, 1'b0);
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (locked === 1'b1) begin
        cnt++;
        if (cnt == 1) begin
          tests++;
          if (attempts !== 2'd3) begin
            fails++;
            $display("FAIL lock_attempts_3: got attempts=%0d, required 3", attempts);
          end else $display("[TB] third wrong entry locks");
        end
      end else if (cnt > 0) break;
    end
    tests++;
    if (cnt != 24) begin
      fails++;
      $display("FAIL lock_duration: got %0d cycles, required 24", cnt);
    end else $display("[TB] locked for 24 cycles");
    tests++;
    if (attempts !== 2'd0) begin
      fails++;
      $display("FAIL lock_release_attempts: got %0d, required 0", attempts);
    end else $display("[TB] attempts cleared after lockout");
    card_off();
  endtask

  task automatic test_timeout();
    int first, pulses;
    card_on();
    press(4'h1);
    press(4'h2);
    first = -1;
    pulses = 0;
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clk);
      if (entry_timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    tests++;
    if (first != 1000 || pulses != 1) begin
      fails++;
      $display("FAIL timeout_pulse: got first=%0d pulses=%0d, required first=1000 pulses=1",
               first, pulses);
    end else $display("[TB] timeout after 1000 idle cycles");
    tests++;
    if (digit_count !== 3'd0 || attempts !== 2'd0) begin
      fails++;
      $display("FAIL timeout_state: got count=%0d attempts=%0d, required 0 0",
               digit_count, attempts);
    end else $display("[TB] partial entry discarded");
    submit(16'h1234, 1'b1);
    repeat (3) @(negedge clk);
    card_off();
  endtask

  task automatic test_key_at_expiry();
    int pulses;
    card_on();
    press(4'h1);
    pulses = 0;
    for (int n = 0; n < 998; n++) begin
      @(negedge clk);
      if (entry_timeout === 1'b1) pulses++;
    end
    press(4'h2);  // accepted on the edge where the timer would expire
    if (entry_timeout === 1'b1) pulses++;
    tests++;
    if (pulses != 0 || digit_count !== 3'd2) begin
      fails++;
      $display("FAIL key_at_expiry: got pulses=%0d count=%0d, required 0 2", pulses, digit_count);
    end else $display("[TB] key wins over expiring timer");
    press(4'h3);
    press(4'h4);
    press(4'hB, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    card_off();
  endtask

  task automatic test_short_and_removal();
    card_on();
    press(4'h1);
    press(4'h2);
    press(4'hB);
    repeat (3) @(negedge clk);
    tests++;
    if (digit_count !== 3'd2 || attempts !== 2'd0) begin
      fails++;
      $display("FAIL short_enter: got count=%0d attempts=%0d, required 2 0", digit_count, attempts);
    end else $display("[TB] short entry ignored");
    press(4'h3);
    press(4'h4);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'hB;
    @(negedge clk);          // now in CHECK
    key_valid = 1'b0;
    card_inserted = 1'b0;
    @(negedge clk);
    tests++;
    if (digit_count !== 3'd0 || attempts !== 2'd0 || pin_entered !== 1'b0) begin
      fails++;
      $display("FAIL removal_in_check: got count=%0d attempts=%0d pulse=%0b, required 0 0 0",
               digit_count, attempts, pin_entered);
    end else $display("[TB] removal in CHECK suppresses entry");
    press(4'h5);
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL idle_ignores_keys: got count=%0d, required 0", digit_count);
    end else $display("[TB] IDLE ignores keys");
    card_on();
    press(4'h1);
    @(negedge clk);
    card_inserted = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h2;
    @(negedge clk);
    key_valid = 1'b0;
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL removal_priority: got count=%0d, required 0", digit_count);
    end else $display("[TB] removal beats simultaneous key");
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    card_on();
    press(4'h1);
    press(4'h2);
    press(4'h3);
    tests++;
    if (digit_count !== 3'd3) begin
      fails++;
      $display("FAIL pre_reset_count: got %0d, required 3", digit_count);
    end else $display("[TB] three digits buffered");
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({pin_entered, pin_ok, locked, entry_timeout, digit_count, attempts} !== 9'd0) begin
      fails++;
      $display("FAIL async_reset: got %b, required 0",
               {pin_entered, pin_ok, locked, entry_timeout, digit_count, attempts});
    end else $display("[TB] async reset clears outputs without a clock edge");
    @(negedge clk);
    reset = 1'b0;
    card_off();
  endtask

  initial begin
    reset = 1'b1;
    card_inserted = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    stored_pin = 16'h1234;
    test_reset();
    test_correct_pin();
    test_edit_overflow();
    test_lockout();
    test_timeout();
    test_key_at_expiry();
    test_short_and_removal();
    test_async_reset();
    repeat (4) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_entries: got %0d outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
